// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one packet-buffer read port and one free-list free port among NUM_PORTS tx controllers
// Ports: clk/rst (sync, active-high); mem_re_i/mem_raddr_i/mem_rgnt_o per-port read request, address, grant;
//        mem_rvalid_o per-port return valid with broadcast mem_rdata_o; mem_re_o/mem_raddr_o/mem_rdata_i memory read port;
//        fl_free_req_i/fl_free_block_idx_i/fl_free_ack_o per-port release; fl_free_req_o/fl_free_block_idx_o/fl_free_rdy_i free-list port.
// Optional MEM_RD_ARB_PERF_EN adds rd_wait_cnt_o, one saturating 16-bit wait counter per port.
package mem_pkg;
    localparam int ADDR_W     = 8;
    localparam int BLOCK_BITS = 32;
endpackage

module mem_read_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int READ_LAT  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             mem_re_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] mem_raddr_i,
    output logic [NUM_PORTS-1:0]             mem_rgnt_o,
    output logic [NUM_PORTS-1:0]             mem_rvalid_o,
    output logic [BLOCK_BITS-1:0]            mem_rdata_o,
    output logic                             mem_re_o,
    output logic [ADDR_W-1:0]                mem_raddr_o,
    input  logic [BLOCK_BITS-1:0]            mem_rdata_i,
    input  logic [NUM_PORTS-1:0]             fl_free_req_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] fl_free_block_idx_i,
    output logic [NUM_PORTS-1:0]             fl_free_ack_o,
    output logic                             fl_free_req_o,
    output logic [ADDR_W-1:0]                fl_free_block_idx_o,
`ifdef MEM_RD_ARB_PERF_EN
    output logic [NUM_PORTS-1:0][15:0]       rd_wait_cnt_o,
`endif
    input  logic                             fl_free_rdy_i
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]               rd_ptr, fr_ptr, rd_win, fr_win;
    logic [READ_LAT-1:0]         tag_v;
    logic [READ_LAT-1:0][PW-1:0] tag_id;

    // Search runs from furthest to nearest so the port just after ptr is written last and wins;
    // i = NUM_PORTS truncates to ptr itself, which therefore has lowest priority.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] win;
        win = '0;
        for (int i = NUM_PORTS; i >= 1; i--)
            if (req[ptr + PW'(i)]) win = ptr + PW'(i);
        return win;
    endfunction

    always_comb begin
        rd_win              = rr_pick(mem_re_i, rd_ptr);
        fr_win              = rr_pick(fl_free_req_i, fr_ptr);
        mem_re_o            = |mem_re_i && !rst;
        mem_raddr_o         = mem_raddr_i[rd_win];
        mem_rgnt_o          = mem_re_o ? NUM_PORTS'(1) << rd_win : '0;
        fl_free_req_o       = |fl_free_req_i && !rst;
        fl_free_block_idx_o = fl_free_block_idx_i[fr_win];
        fl_free_ack_o       = (fl_free_req_o && fl_free_rdy_i) ? NUM_PORTS'(1) << fr_win : '0;
        mem_rvalid_o        = (tag_v[READ_LAT-1] && !rst) ? NUM_PORTS'(1) << tag_id[READ_LAT-1] : '0;
        mem_rdata_o         = mem_rdata_i;
    end

    // Tag pipeline mirrors the memory latency so each returning beat carries its requester's id.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= PW'(NUM_PORTS - 1);
            fr_ptr <= PW'(NUM_PORTS - 1);
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            rd_ptr    <= mem_re_o ? rd_win : rd_ptr;
            fr_ptr    <= (fl_free_req_o && fl_free_rdy_i) ? fr_win : fr_ptr;
            tag_v[0]  <= mem_re_o;
            tag_id[0] <= rd_win;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

`ifdef MEM_RD_ARB_PERF_EN
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            rd_wait_cnt_o[p] <= rst ? '0 :
                (mem_re_i[p] && !mem_rgnt_o[p] && rd_wait_cnt_o[p] != 16'hFFFF) ? rd_wait_cnt_o[p] + 16'd1 :
                rd_wait_cnt_o[p];
    end
`endif

endmodule
